// File: rtl/vga_bounce_pic.sv
// Pixel source for the VGA sync generator: a solid square bouncing inside the visible
// area over a fixed background, recolouring from an 8-entry palette on every wall hit.
module vga_bounce_pic #(
    parameter int          H_VALID   = 640,
    parameter int          V_VALID   = 480,
    parameter int          BOX_SIZE  = 64,
    parameter int          STEP      = 2,
    parameter int          FRAME_DIV = 1,
    parameter logic [15:0] BG_COLOR  = 16'hFFFF
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        move_en,
    output logic [15:0] pix_data,
    output logic        frame_end
);

    localparam int          CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [10:0] LIM_X    = 11'(H_VALID - BOX_SIZE);
    localparam logic [10:0] LIM_Y    = 11'(V_VALID - BOX_SIZE);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [9:0]  STEP_N   = 10'(STEP);
    localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);
    localparam logic [9:0]  H_LAST   = 10'(H_VALID - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_VALID - 1);
    localparam logic [9:0]  NO_REQ   = 10'h3FF;

    typedef struct packed {
        logic [9:0] pos;
        logic       neg;
        logic       bounce;
    } axis_t;

    logic [9:0]       r_box_x;
    logic [9:0]       r_box_y;
    logic             r_dir_x_neg;
    logic             r_dir_y_neg;
    logic [2:0]       r_color_idx;
    logic [CNT_W-1:0] r_frm_cnt;

    logic             w_no_req;
    logic             w_in_x;
    logic             w_in_y;
    logic             w_fe;
    logic             w_move;
    logic [15:0]      w_box_color;
    axis_t            w_nx_x;
    axis_t            w_nx_y;

    // One move along an axis; overshooting a wall clamps onto it and reverses.
    function automatic axis_t axis_step(input logic [9:0] pos, input logic neg,
                                        input logic [10:0] lim);
        axis_t res;
        res = '{pos: pos, neg: neg, bounce: 1'b0};
        if (!neg) begin
            if ({1'b0, pos} + STEP_W >= lim) begin
                res.pos    = lim[9:0];
                res.neg    = 1'b1;
                res.bounce = 1'b1;
            end else begin
                res.pos = pos + STEP_N;
            end
        end else begin
            if ({1'b0, pos} <= STEP_W) begin
                res.pos    = 10'd0;
                res.neg    = 1'b0;
                res.bounce = 1'b1;
            end else begin
                res.pos = pos - STEP_N;
            end
        end
        return res;
    endfunction

    assign w_no_req = (pix_x == NO_REQ) || (pix_y == NO_REQ);
    assign w_in_x   = ({1'b0, pix_x} >= {1'b0, r_box_x}) &&
                      ({1'b0, pix_x} <  {1'b0, r_box_x} + BOX_W);
    assign w_in_y   = ({1'b0, pix_y} >= {1'b0, r_box_y}) &&
                      ({1'b0, pix_y} <  {1'b0, r_box_y} + BOX_W);
    assign w_fe     = (pix_x == H_LAST) && (pix_y == V_LAST);
    assign w_move   = w_fe && move_en && (r_frm_cnt == CNT_LAST);
    assign w_nx_x   = axis_step(r_box_x, r_dir_x_neg, LIM_X);
    assign w_nx_y   = axis_step(r_box_y, r_dir_y_neg, LIM_Y);

    always_comb begin
        w_box_color = 16'h0000;
        case (r_color_idx)
            3'd0: w_box_color = 16'hF800;
            3'd1: w_box_color = 16'hFC00;
            3'd2: w_box_color = 16'hFFE0;
            3'd3: w_box_color = 16'h07E0;
            3'd4: w_box_color = 16'h07FF;
            3'd5: w_box_color = 16'h001F;
            3'd6: w_box_color = 16'hF81F;
            3'd7: w_box_color = 16'h0000;
            default: w_box_color = 16'h0000;
        endcase
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data  <= 16'h0000;
            frame_end <= 1'b0;
        end else begin
            frame_end <= w_fe;
            if (w_no_req)
                pix_data <= 16'h0000;
            else if (w_in_x && w_in_y)
                pix_data <= w_box_color;
            else
                pix_data <= BG_COLOR;
        end
    end

    // Motion state only changes on the frame event, so the frame's last pixel still sees
    // the old position above.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_box_x     <= 10'd0;
            r_box_y     <= 10'd0;
            r_dir_x_neg <= 1'b0;
            r_dir_y_neg <= 1'b0;
            r_color_idx <= 3'd0;
            r_frm_cnt   <= '0;
        end else if (w_fe && move_en) begin
            if (w_move)
                r_frm_cnt <= '0;
            else
                r_frm_cnt <= r_frm_cnt + 1'b1;
            if (w_move) begin
                r_box_x     <= w_nx_x.pos;
                r_dir_x_neg <= w_nx_x.neg;
                r_box_y     <= w_nx_y.pos;
                r_dir_y_neg <= w_nx_y.neg;
                if (w_nx_x.bounce || w_nx_y.bounce)
                    r_color_idx <= r_color_idx + 3'd1;
            end
        end
    end

endmodule
